// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add/normalize datapath.
package fp_pkg;

  localparam int          MANT_W  = 32;
  localparam int          EXP_W   = 8;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam int          GRS_W   = 8;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W:0]   sum;
  } stage1_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; reports 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize.sv
// Two-stage mantissa add, normalize, round-to-nearest-even and IEEE-754 pack.
// Optional status output {overflow, inexact, zero} under macro FPADD_STATUS_EN.
module fp_add_normalize
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              signA,
  input  logic              signB,
  input  logic [EXP_W-1:0]  exponentIn,
  input  logic [MANT_W-1:0] alignedMantissaA,
  input  logic [MANT_W-1:0] alignedMantissaB,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [31:0]       result
`ifdef FPADD_STATUS_EN
  ,
  output logic [2:0]        status
`endif
);

  function automatic logic round_up(input logic [31:0] m);
    return m[GRS_W-1] & (m[GRS_W-2] | (|m[GRS_W-3:0]) | m[GRS_W]);
  endfunction

  function automatic logic is_overflow(input logic [8:0] exp_field);
    return exp_field >= {1'b0, EXP_MAX};
  endfunction

  logic    r_vld_p1, r_vld_p2;
  stage1_t r_s1_p1;
  logic [31:0] r_result_p2;
  logic    w_adv1, w_adv2;

  assign w_adv2    = !r_vld_p2 || ready_out;
  assign w_adv1    = !r_vld_p1 || w_adv2;
  assign ready_in  = w_adv1;
  assign valid_out = r_vld_p2;
  assign result    = r_result_p2;

  // ---- stage 1: signed-magnitude add/subtract ----
  stage1_t w_s1;
  always_comb begin
    w_s1.exponent = (exponentIn == '0) ? EXP_W'(1) : exponentIn;
    w_s1.sign     = 1'b0;
    w_s1.sum      = '0;
    if (signA == signB) begin
      w_s1.sum  = {1'b0, alignedMantissaA} + {1'b0, alignedMantissaB};
      w_s1.sign = signA;
    end else if (alignedMantissaA > alignedMantissaB) begin
      w_s1.sum  = {1'b0, alignedMantissaA} - {1'b0, alignedMantissaB};
      w_s1.sign = signA;
    end else if (alignedMantissaB > alignedMantissaA) begin
      w_s1.sum  = {1'b0, alignedMantissaB} - {1'b0, alignedMantissaA};
      w_s1.sign = signB;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && valid_in) r_s1_p1 <= w_s1;
  end

  // ---- stage 2: normalize, round, pack ----
  logic [5:0]  w_lz;
  logic [7:0]  w_shift, w_shift_lim;
  logic [31:0] w_norm_m;
  logic [8:0]  w_exp9, w_exp_field;
  logic [31:0] w_rounded;
  logic        w_zero, w_ovf;
  fp32_t       w_res;

  lzc32 u_lzc (.i_data(r_s1_p1.sum[31:0]), .o_count(w_lz));

  always_comb begin
    w_shift_lim = r_s1_p1.exponent - 8'd1;
    w_shift     = '0;
    if (r_s1_p1.sum[32]) begin
      w_norm_m = {r_s1_p1.sum[32:2], r_s1_p1.sum[1] | r_s1_p1.sum[0]};
      w_exp9   = {1'b0, r_s1_p1.exponent} + 9'd1;
    end else begin
      // Never shift below exponent 1; whatever remains unnormalized is subnormal.
      w_shift  = ({2'b00, w_lz} < w_shift_lim) ? {2'b00, w_lz} : w_shift_lim;
      w_norm_m = r_s1_p1.sum[31:0] << w_shift;
      w_exp9   = {1'b0, r_s1_p1.exponent} - {1'b0, w_shift};
    end
    w_exp_field = w_norm_m[31] ? w_exp9 : 9'd0;
    // Adding into the packed {exp, frac} lets fraction carry bump the exponent.
    w_rounded   = {w_exp_field, w_norm_m[30:8]} + 32'(round_up(w_norm_m));
    w_ovf       = is_overflow(w_rounded[31:23]);
    w_zero      = (r_s1_p1.sum == '0);
    if (w_zero)     w_res = '0;
    else if (w_ovf) w_res = '{sign: r_s1_p1.sign, exponent: EXP_MAX, fraction: 23'd0};
    else            w_res = {r_s1_p1.sign, w_rounded[30:0]};
  end

`ifdef FPADD_STATUS_EN
  logic [2:0] w_status;
  assign w_status = {w_ovf & ~w_zero, (|w_norm_m[GRS_W-1:0]) | (w_ovf & ~w_zero), w_zero};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
`ifdef FPADD_STATUS_EN
      status      <= '0;
`endif
    end else begin
      if (w_adv1) r_vld_p1 <= valid_in;
      if (w_adv2) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_result_p2 <= w_res;
`ifdef FPADD_STATUS_EN
          status      <= w_status;
`endif
        end
      end
    end
  end

endmodule
